shared_reg_arbiter: RTL



---
 rtl/shared_reg_arbiter.sv | 101 ++++++++++
 1 files changed

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter for up to four requesters sharing one WIDTH-bit register.
// The current owner either loads its data lane or forces the register to all ones.
module shared_reg_arbiter #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         req,
    input  logic [3:0]         set_req,
    input  logic [4*WIDTH-1:0] din,
    output logic [3:0]         gnt,
    output logic [1:0]         owner,
    output logic               busy,
    output logic [WIDTH-1:0]   q
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [3:0] HOLD = 4'(MAX_HOLD);

    state_t           state, state_n;
    logic [1:0]       ptr, ptr_n;
    logic [3:0]       cnt, cnt_n, cnt_inc;
    logic [3:0]       gnt_n;
    logic [1:0]       owner_n;
    logic             busy_n;
    logic [WIDTH-1:0] q_n;
    logic [1:0]       pick;
    logic             found;

    // First active requester at or after ptr, wrapping modulo 4.
    always_comb begin
        pick  = ptr;
        found = 1'b0;
        for (int unsigned k = 0; k < 4; k++) begin
            if (!found && req[ptr + 2'(k)]) begin
                pick  = ptr + 2'(k);
                found = 1'b1;
            end
        end
    end

    assign cnt_inc = cnt + 4'd1;

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        cnt_n   = cnt;
        gnt_n   = gnt;
        owner_n = owner;
        busy_n  = busy;
        q_n     = q;
        case (state)
            IDLE: begin
                if (found) begin
                    owner_n = pick;
                    gnt_n   = 4'b0001 << pick;
                    busy_n  = 1'b1;
                    cnt_n   = '0;
                    state_n = GRANT;
                end
            end
            GRANT: begin
                if (req[owner]) begin
                    q_n   = set_req[owner] ? '1 : din[owner*WIDTH +: WIDTH];
                    cnt_n = cnt_inc;
                end
                // Release on a dropped request or on the last permitted write.
                if (!req[owner] || cnt_inc == HOLD) begin
                    state_n = IDLE;
                    gnt_n   = '0;
                    busy_n  = 1'b0;
                    ptr_n   = owner + 2'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            cnt   <= '0;
            gnt   <= '0;
            owner <= '0;
            busy  <= 1'b0;
            q     <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            cnt   <= cnt_n;
            gnt   <= gnt_n;
            owner <= owner_n;
            busy  <= busy_n;
            q     <= q_n;
        end
    end

endmodule
